mem_access_unit: RTL and testbench

//  Parametrised load/store bridge between the MIPS datapath and the Avalon-style memory bus.

---
 rtl/mem_access_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store bridge between the MIPS datapath and an Avalon-style bus: one request at a time,
// byte-lane placement on the way out, extraction / sign-extension / LWL-LWR merge on the way back.
// state  | meaning
// S_IDLE | ready for a request; errors short-circuit straight to S_RESP
// S_BUS  | strobe held until waitrequest drops or the timeout counter expires
// S_RESP | one-cycle response pulse
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit SWAP_BYTES     = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_opcode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic                  bus_read,
    output logic                  bus_write,
    output logic [3:0]            bus_byteenable,
    output logic [31:0]           bus_writedata,
    input  logic [31:0]           bus_readdata,
    input  logic                  bus_waitrequest
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    // Lane order <-> CPU order; byte reversal is its own inverse so one function serves both ways.
    function automatic logic [31:0] reorder(input logic [31:0] v);
        return SWAP_BYTES ? {v[7:0], v[15:8], v[23:16], v[31:24]} : v;
    endfunction

    function automatic logic [1:0] byte_sig(input logic [1:0] off);
        return SWAP_BYTES ? ~off : off;
    endfunction

    // Significance of the low byte of an aligned halfword at offset off.
    function automatic logic [1:0] half_sig(input logic [1:0] off);
        return SWAP_BYTES ? (2'd2 - off) : off;
    endfunction

    function automatic logic [31:0] load_result(input logic [5:0] op, input logic [1:0] a,
                                                input logic [31:0] w, input logic [31:0] rt);
        logic [4:0]  sb;
        logic [4:0]  sh;
        logic [1:0]  e;
        logic [31:0] ones;
        logic [31:0] byte_v;
        logic [31:0] half_v;
        logic [31:0] r;
        sb     = {byte_sig(a), 3'b000};
        sh     = {half_sig(a), 3'b000};
        e      = SWAP_BYTES ? a : ~a;
        ones   = '1;
        byte_v = w >> sb;
        half_v = w >> sh;
        case (op)
            OP_LB:   r = {{24{byte_v[7]}}, byte_v[7:0]};
            OP_LBU:  r = {24'h0, byte_v[7:0]};
            OP_LH:   r = {{16{half_v[15]}}, half_v[15:0]};
            OP_LHU:  r = {16'h0, half_v[15:0]};
            OP_LWL:  r = (w << {e, 3'b000}) | (rt & ~(ones << {e, 3'b000}));
            OP_LWR:  r = (w >> {~e, 3'b000}) | (rt & ~(ones >> {~e, 3'b000}));
            default: r = w;
        endcase
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [5:0]              op_q, op_d;
    logic [1:0]              a_q, a_d;
    logic [31:0]             rt_old_q, rt_old_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    bus_read_q, bus_read_d;
    logic                    bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0]   bus_address_q, bus_address_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wd_q, wd_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  a_in;
    logic        is_load_in;
    logic        is_store_in;
    logic        misaligned_in;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] cnt_inc;

    always_comb begin
        a_in          = req_addr[1:0];
        is_load_in    = 1'b0;
        is_store_in   = 1'b0;
        misaligned_in = 1'b0;
        be_in         = 4'b1111;
        wd_in         = 32'h0;
        case (req_opcode)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load_in = 1'b1;
            OP_LH, OP_LHU: begin
                is_load_in    = 1'b1;
                misaligned_in = a_in[0];
            end
            OP_LW: begin
                is_load_in    = 1'b1;
                misaligned_in = (a_in != 2'b00);
            end
            OP_SB: begin
                is_store_in = 1'b1;
                be_in       = 4'b0001 << a_in;
                wd_in       = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                is_store_in   = 1'b1;
                misaligned_in = a_in[0];
                be_in         = 4'b0011 << a_in;
                wd_in         = reorder({16'h0, req_wdata[15:0]} << {half_sig(a_in), 3'b000});
            end
            OP_SW: begin
                is_store_in   = 1'b1;
                misaligned_in = (a_in != 2'b00);
                wd_in         = reorder(req_wdata);
            end
            default: ;
        endcase
    end

    assign cnt_inc = cnt_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        rt_old_d      = rt_old_q;
        cnt_d         = cnt_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        bus_address_d = bus_address_q;
        be_d          = be_q;
        wd_d          = wd_q;
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_rdata_d   = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_opcode;
                    a_d      = a_in;
                    rt_old_d = req_rt_old;
                    if (misaligned_in || !(is_load_in || is_store_in)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d       = S_BUS;
                        bus_read_d    = is_load_in;
                        bus_write_d   = is_store_in;
                        bus_address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d          = be_in;
                        wd_d          = wd_in;
                    end
                end
            end
            S_BUS: begin
                if (!bus_waitrequest) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_read_q ? load_result(op_q, a_q, reorder(bus_readdata), rt_old_q)
                                             : 32'h0;
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == 32'(TIMEOUT_CYCLES)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
                if (state_d == S_RESP) begin
                    bus_read_d    = 1'b0;
                    bus_write_d   = 1'b0;
                    bus_address_d = '0;
                    be_d          = 4'b0000;
                    wd_d          = 32'h0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 32'h0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 6'h0;
            a_q           <= 2'b00;
            rt_old_q      <= 32'h0;
            cnt_q         <= 32'h0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_address_q <= '0;
            be_q          <= 4'b0000;
            wd_q          <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            rt_old_q      <= rt_old_d;
            cnt_q         <= cnt_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            bus_address_q <= bus_address_d;
            be_q          <= be_d;
            wd_q          <= wd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE) && !reset;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_address    = bus_address_q;
    assign bus_byteenable = be_q;
    assign bus_writedata  = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a big-endian and a little-endian instance share stimulus and are
// checked against a byte-significance reference model.
module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;

    logic        req_ready_o      [2];
    logic        rsp_valid_o      [2];
    logic        rsp_error_o      [2];
    logic [31:0] rsp_rdata_o      [2];
    logic [31:0] bus_address_o    [2];
    logic        bus_read_o       [2];
    logic        bus_write_o      [2];
    logic [3:0]  bus_byteenable_o [2];
    logic [31:0] bus_writedata_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW), .SWAP_BYTES(1'b1), .TIMEOUT_CYCLES(TO)) u_be (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[0]),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .rsp_valid(rsp_valid_o[0]), .rsp_rdata(rsp_rdata_o[0]), .rsp_error(rsp_error_o[0]),
        .bus_address(bus_address_o[0]), .bus_read(bus_read_o[0]), .bus_write(bus_write_o[0]),
        .bus_byteenable(bus_byteenable_o[0]), .bus_writedata(bus_writedata_o[0]),
        .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest));

    mem_access_unit #(.ADDR_WIDTH(AW), .SWAP_BYTES(1'b0), .TIMEOUT_CYCLES(TO)) u_le (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[1]),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .rsp_valid(rsp_valid_o[1]), .rsp_rdata(rsp_rdata_o[1]), .rsp_error(rsp_error_o[1]),
        .bus_address(bus_address_o[1]), .bus_read(bus_read_o[1]), .bus_write(bus_write_o[1]),
        .bus_byteenable(bus_byteenable_o[1]), .bus_writedata(bus_writedata_o[1]),
        .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest));

    // ---------------- reference model ----------------
    function automatic int sig_of(bit swap, int k);
        return swap ? 3 - k : k;
    endfunction

    function automatic logic [31:0] to_cpu(bit swap, logic [31:0] rd);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*sig_of(swap, k) +: 8] = rd[8*k +: 8];
        return w;
    endfunction

    function automatic bit is_load_op(logic [5:0] op);
        return op inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110};
    endfunction

    function automatic bit model_err(logic [5:0] op, int a);
        if (!(is_load_op(op) || op inside {6'b101000, 6'b101001, 6'b101011})) return 1'b1;
        if (op inside {6'b100001, 6'b100101, 6'b101001} && (a % 2) != 0) return 1'b1;
        if (op inside {6'b100011, 6'b101011} && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(bit swap, logic [5:0] op, int a,
                                               logic [31:0] rd, logic [31:0] rt);
        logic [31:0] w, ones, r;
        logic [7:0]  b, hi, lo;
        logic [63:0] m;
        int          e, sh;
        w    = to_cpu(swap, rd);
        b    = rd[8*a +: 8];
        ones = '1;
        e    = swap ? a : 3 - a;
        if (swap) begin
            hi = rd[8*a +: 8];
            lo = rd[8*((a+1)%4) +: 8];
        end else begin
            lo = rd[8*a +: 8];
            hi = rd[8*((a+1)%4) +: 8];
        end
        case (op)
            6'b100000: r = {{24{b[7]}}, b};
            6'b100100: r = {24'h0, b};
            6'b100001: r = {{16{hi[7]}}, hi, lo};
            6'b100101: r = {16'h0, hi, lo};
            6'b100011: r = w;
            6'b100010: begin
                m = (64'd1 << (8*e)) - 64'd1;
                r = 32'(64'(w) << (8*e)) | (rt & m[31:0]);
            end
            6'b100110: begin
                sh = 8 * (3 - e);
                r  = (w >> sh) | (rt & ~(ones >> sh));
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] model_be(logic [5:0] op, int a);
        if (op == 6'b101000) return 4'(1 << a);
        if (op == 6'b101001) return 4'(3 << a);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(bit swap, logic [5:0] op, int a, logic [31:0] wd);
        logic [31:0] r;
        r = '0;
        if (op == 6'b101000) r = {4{wd[7:0]}};
        else if (op == 6'b101001) begin
            r[8*a +: 8]     = swap ? wd[15:8] : wd[7:0];
            r[8*(a+1) +: 8] = swap ? wd[7:0]  : wd[15:8];
        end else if (op == 6'b101011) begin
            for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*sig_of(swap, k) +: 8];
        end
        return r;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic do_txn(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rt,
                          input logic [31:0] rd, input int nwait);
        bit          swap, err, ld;
        int          a;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, mask, eaddr;
        a     = int'(addr[1:0]);
        err   = model_err(op, a);
        ld    = is_load_op(op);
        eaddr = {addr[31:2], 2'b00};
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d req_ready before accept got %b exp 1", name, d, req_ready_o[d]);
            end
        end
        req_opcode = op; req_addr = addr; req_wdata = wdata; req_rt_old = rt;
        bus_readdata = rd; bus_waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
        if (err) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rsp_valid_o[d] !== 1'b1 || rsp_error_o[d] !== 1'b1 || rsp_rdata_o[d] !== 32'h0 ||
                    bus_read_o[d] !== 1'b0 || bus_write_o[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s dut%0d error rsp got v=%b e=%b d=%h r=%b w=%b exp v=1 e=1 d=0 r=0 w=0",
                             name, d, rsp_valid_o[d], rsp_error_o[d], rsp_rdata_o[d], bus_read_o[d], bus_write_o[d]);
                end
            end
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rsp_valid_o[d] !== 1'b0 || bus_read_o[d] !== 1'b0 || bus_write_o[d] !== 1'b0 ||
                    req_ready_o[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s dut%0d after error got v=%b r=%b w=%b rdy=%b exp v=0 r=0 w=0 rdy=1",
                             name, d, rsp_valid_o[d], bus_read_o[d], bus_write_o[d], req_ready_o[d]);
                end
            end
            return;
        end
        for (int c = 0; c <= nwait; c++) begin
            bus_waitrequest = (c < nwait);
            for (int d = 0; d < 2; d++) begin
                swap = (d == 0);
                ebe  = model_be(op, a);
                ewd  = model_wd(swap, op, a, wdata);
                mask = (op == 6'b101001) ? {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}} : 32'hFFFF_FFFF;
                checks++;
                if (bus_read_o[d] !== ld || bus_write_o[d] !== !ld || bus_address_o[d] !== eaddr ||
                    bus_byteenable_o[d] !== ebe) begin
                    errors++;
                    $display("FAIL %s dut%0d bus ctl cyc%0d got r=%b w=%b a=%h be=%b exp r=%b w=%b a=%h be=%b",
                             name, d, c, bus_read_o[d], bus_write_o[d], bus_address_o[d], bus_byteenable_o[d],
                             ld, !ld, eaddr, ebe);
                end
                checks++;
                if ((bus_writedata_o[d] & mask) !== ewd) begin
                    errors++;
                    $display("FAIL %s dut%0d writedata got %h exp %h", name, d, bus_writedata_o[d] & mask, ewd);
                end
                checks++;
                if (rsp_valid_o[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s dut%0d early rsp_valid cyc%0d got %b exp 0", name, d, c, rsp_valid_o[d]);
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            swap = (d == 0);
            erd  = ld ? model_load(swap, op, a, rd, rt) : 32'h0;
            checks++;
            if (rsp_valid_o[d] !== 1'b1 || rsp_error_o[d] !== 1'b0 || rsp_rdata_o[d] !== erd ||
                bus_read_o[d] !== 1'b0 || bus_write_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d rsp got v=%b e=%b d=%h r=%b w=%b exp v=1 e=0 d=%h r=0 w=0",
                         name, d, rsp_valid_o[d], rsp_error_o[d], rsp_rdata_o[d], bus_read_o[d],
                         bus_write_o[d], erd);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid_o[d] !== 1'b0 || req_ready_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d rsp pulse end got v=%b rdy=%b exp v=0 rdy=1",
                         name, d, rsp_valid_o[d], req_ready_o[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_opcode = 6'b101011; req_addr = 32'h100;
        req_wdata = 32'h1234_5678; req_rt_old = 32'h0; bus_readdata = 32'h0; bus_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready_o[d] !== 1'b0 || rsp_valid_o[d] !== 1'b0 || rsp_error_o[d] !== 1'b0 ||
                rsp_rdata_o[d] !== 32'h0 || bus_read_o[d] !== 1'b0 || bus_write_o[d] !== 1'b0 ||
                bus_address_o[d] !== 32'h0 || bus_byteenable_o[d] !== 4'h0 || bus_writedata_o[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset dut%0d outputs got rdy=%b v=%b e=%b d=%h r=%b w=%b a=%h be=%b wd=%h exp all 0",
                         d, req_ready_o[d], rsp_valid_o[d], rsp_error_o[d], rsp_rdata_o[d], bus_read_o[d],
                         bus_write_o[d], bus_address_o[d], bus_byteenable_o[d], bus_writedata_o[d]);
            end
        end
        req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_txn("sw_0x100",  6'b101011, 32'h100, 32'h1122_3344, 32'h0, 32'h0, 0);
        do_txn("lb_0x103",  6'b100000, 32'h103, 32'h0, 32'h0, 32'h80FF_EE11, 0);
        do_txn("lbu_0x103", 6'b100100, 32'h103, 32'h0, 32'h0, 32'h80FF_EE11, 0);
        do_txn("lwl_0x101", 6'b100010, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        do_txn("lwr_0x101", 6'b100110, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        do_txn("sh_0x102",  6'b101001, 32'h102, 32'hCAFE_BEEF, 32'h0, 32'h0, 0);
        do_txn("sb_0x101",  6'b101000, 32'h101, 32'h0000_00A5, 32'h0, 32'h0, 0);
        do_txn("lh_0x102",  6'b100001, 32'h102, 32'h0, 32'h0, 32'h8F01_7F02, 0);
        do_txn("lhu_0x100", 6'b100101, 32'h100, 32'h0, 32'h0, 32'h8F01_7F82, 0);
    endtask

    task automatic test_wait_states();
        do_txn("lw_wait3", 6'b100011, 32'h200, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
        do_txn("sw_wait2", 6'b101011, 32'h204, 32'h0102_0304, 32'h0, 32'h0, 2);
    endtask

    task automatic test_errors();
        do_txn("err_lh_odd",  6'b100001, 32'h101, 32'h0, 32'h0, 32'h1234_5678, 0);
        do_txn("err_op0",     6'b000000, 32'h100, 32'h0, 32'h0, 32'h1234_5678, 0);
        do_txn("err_sw_0x102", 6'b101011, 32'h102, 32'h5555_AAAA, 32'h0, 32'h0, 0);
        do_txn("err_lw_0x103", 6'b100011, 32'h103, 32'h0, 32'h0, 32'h0, 0);
        do_txn("err_sh_0x103", 6'b101001, 32'h103, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        int strobes;
        bit done;
        strobes = 0; done = 1'b0;
        req_opcode = 6'b100011; req_addr = 32'h40; bus_readdata = 32'h1357_9BDF;
        bus_waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (rsp_valid_o[0] === 1'b1) done = 1'b1;
            else begin
                if (bus_read_o[0] === 1'b1) strobes++;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done || strobes != TO) begin
            errors++;
            $display("FAIL timeout strobe cycles got %0d (rsp seen %b) exp %0d", strobes, done, TO);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid_o[d] !== 1'b1 || rsp_error_o[d] !== 1'b1 || rsp_rdata_o[d] !== 32'h0 ||
                bus_read_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL timeout dut%0d rsp got v=%b e=%b d=%h r=%b exp v=1 e=1 d=0 r=0",
                         d, rsp_valid_o[d], rsp_error_o[d], rsp_rdata_o[d], bus_read_o[d]);
            end
        end
        bus_waitrequest = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_bus();
        req_opcode = 6'b100011; req_addr = 32'h80; bus_waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bus_read_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL midreset dut%0d bus_read before reset got %b exp 1", d, bus_read_o[d]);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bus_read_o[d] !== 1'b0 || bus_write_o[d] !== 1'b0 || rsp_valid_o[d] !== 1'b0 ||
                req_ready_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset dut%0d in reset got r=%b w=%b v=%b rdy=%b exp all 0",
                         d, bus_read_o[d], bus_write_o[d], rsp_valid_o[d], req_ready_o[d]);
            end
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL midreset dut%0d req_ready after release got %b exp 1", d, req_ready_o[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid_o[d] !== 1'b0 || bus_read_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset dut%0d stale activity got v=%b r=%b exp 0 0",
                         d, rsp_valid_o[d], bus_read_o[d]);
            end
        end
        bus_waitrequest = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          pulses;
        logic [31:0] rd, erd;
        pulses = 0;
        rd = $urandom;
        req_opcode = 6'b100011; req_addr = 32'h300; req_rt_old = 32'h0;
        bus_readdata = rd; bus_waitrequest = 1'b0; req_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (rsp_valid_o[0] === 1'b1) begin
                pulses++;
                for (int d = 0; d < 2; d++) begin
                    erd = model_load(d == 0, 6'b100011, 0, rd, 32'h0);
                    checks++;
                    if (rsp_rdata_o[d] !== erd) begin
                        errors++;
                        $display("FAIL b2b dut%0d rdata got %h exp %h", d, rsp_rdata_o[d], erd);
                    end
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b response count in 9 cycles got %0d exp 3", pulses);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] ops [13];
        ops = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                6'b101000, 6'b101001, 6'b101011, 6'b000000, 6'b111111, 6'b100111};
        for (int i = 0; i < 40; i++) begin
            do_txn("random", ops[$urandom_range(0, 12)], $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_wait_states();
        test_errors();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
